// File: rtl/uart_byte_io.sv
// ---------------------------------------------------------------------------
// uart_byte_io
//   Byte-level UART I/O engine serving a main command decoder. One command is
//   accepted at a time: "send byte" shifts an 8N1 frame out on txd, "receive
//   byte" hands over the oldest byte from a small RX queue. The receiver runs
//   on its own and fills the queue whenever a good frame arrives on rxd.
//
// Command handshake: uart_go is a one-cycle strobe, sampled only while the
//   command FSM is IDLE (strobes in any other state are ignored). Every
//   accepted command finishes with exactly one uart_done pulse, in the same
//   cycle the FSM is back in IDLE, so a new strobe may arrive in that cycle.
//   rx_data is updated in the uart_done cycle of a receive and then holds.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit (even, >= 4)
//   RXQ_AW       : log2 of the RX queue depth
//
// Ports
//   clk, rstn     : system clock (posedge), async active-low reset
//   uart_go       : command strobe
//   rors          : command type with uart_go, 1 = send, 0 = receive
//   tx_data       : byte to send with uart_go when rors = 1
//   uart_done     : one-cycle completion pulse
//   rx_data       : last byte handed over by a receive command
//   txd           : serial output, idle high
//   rxd           : serial input, asynchronous to clk
//   rx_overrun    : sticky, a received byte was dropped (queue full)
//   rx_frame_err  : sticky, a frame had a low stop bit
//   cmd_state     : debug view of the command FSM state
//   rx_state      : debug view of the receiver FSM state
// ---------------------------------------------------------------------------
module uart_byte_io #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RXQ_AW       = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_go,
  input  logic       rors,
  input  logic [7:0] tx_data,
  output logic       uart_done,
  output logic [7:0] rx_data,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic [1:0] cmd_state,
  output logic [2:0] rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << RXQ_AW;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [RXQ_AW:0]  Q_FULL   = {1'b1, {RXQ_AW{1'b0}}};

  // Command FSM encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TX_BUSY = 2'd1;
  localparam logic [1:0] RX_WAIT = 2'd2;

  // Receiver FSM encoding
  localparam logic [2:0] R_IDLE      = 3'd0;
  localparam logic [2:0] R_START     = 3'd1;
  localparam logic [2:0] R_DATA      = 3'd2;
  localparam logic [2:0] R_STOP      = 3'd3;
  localparam logic [2:0] R_WAIT_HIGH = 3'd4;

  // -------------------------------------------------------------------------
  // Transmit path and command FSM
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;    // bit currently on the line: 0 start .. 9 stop
  logic [8:0]       tx_frame;  // bits still to send, next one at [0]

  logic [RXQ_AW:0]   q_count;
  logic [RXQ_AW-1:0] rd_ptr;
  logic [RXQ_AW-1:0] wr_ptr;
  logic [7:0]        q_mem [DEPTH];

  logic pop;
  assign pop = (cmd_state == RX_WAIT) && (q_count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_state <= IDLE;
      txd       <= 1'b1;
      uart_done <= 1'b0;
      rx_data   <= 8'h00;
      tx_cnt    <= '0;
      tx_bit    <= 4'd0;
      tx_frame  <= '1;
    end else begin
      uart_done <= 1'b0;
      case (cmd_state)
        IDLE: begin
          if (uart_go) begin
            if (rors) begin
              // Start bit goes out in the cycle right after acceptance.
              tx_frame  <= {1'b1, tx_data};
              txd       <= 1'b0;
              tx_cnt    <= '0;
              tx_bit    <= 4'd0;
              cmd_state <= TX_BUSY;
            end else begin
              cmd_state <= RX_WAIT;
            end
          end
        end
        TX_BUSY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              txd       <= 1'b1;
              uart_done <= 1'b1;
              cmd_state <= IDLE;
            end else begin
              // The 1 shifted in at the top becomes the stop bit.
              txd      <= tx_frame[0];
              tx_frame <= {1'b1, tx_frame[8:1]};
              tx_bit   <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (pop) begin
            rx_data   <= q_mem[rd_ptr];
            uart_done <= 1'b1;
            cmd_state <= IDLE;
          end
        end
        default: cmd_state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // rxd synchronizer plus one history flop for edge detection.
  // The flops reset low so a line that is already low when reset releases
  // never looks like a falling edge; the receiver only arms once it has seen
  // the line high and then low again.
  // -------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_s3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM
  // rx_cnt starts at 1 on the edge detect because the low level was already
  // present in rx_s2 one cycle earlier; the start check at BIT_HALF and every
  // later check at BIT_LAST then land on the bit centers.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             push;

  assign push = (rx_state == R_STOP) && (rx_cnt == BIT_LAST) && rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state     <= R_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_frame_err <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= CNT_W'(1);
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt == BIT_HALF) begin
            rx_cnt <= '0;
            rx_bit <= 3'd0;
            // A line that is high again at mid start bit was a glitch.
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= R_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= R_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= R_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_WAIT_HIGH: begin
          if (rx_s2) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RX queue: circular buffer, count has one extra bit to tell full from
  // empty. A push while full is still accepted if a pop frees the slot in the
  // same cycle; the pop reads the old head before the write lands.
  // -------------------------------------------------------------------------
  logic push_ok;
  assign push_ok = push && ((q_count != Q_FULL) || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && !push_ok) rx_overrun <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) q_mem[wr_ptr] <= rx_shift;
  end

endmodule

// File: tb/tb_uart_byte_io.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_io
//   Directed bench for uart_byte_io with CLKS_PER_BIT = 4. Inputs change 1 ns
//   after a rising edge, outputs are looked at on the falling edge. "cyc"
//   counts rising edges; a value seen on the falling edge after edge k
//   belongs to cycle k.
// ---------------------------------------------------------------------------
module tb_uart_byte_io;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       uart_go;
  logic       rors;
  logic [7:0] tx_data;
  logic       uart_done;
  logic [7:0] rx_data;
  logic       txd;
  logic       rxd;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic [1:0] cmd_state;
  logic [2:0] rx_state;

  uart_byte_io #(.CLKS_PER_BIT(CPB), .RXQ_AW(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_go      (uart_go),
    .rors         (rors),
    .tx_data      (tx_data),
    .uart_done    (uart_done),
    .rx_data      (rx_data),
    .txd          (txd),
    .rxd          (rxd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .cmd_state    (cmd_state),
    .rx_state     (rx_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int go_cyc = 0;
  int frame_start_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (uart_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_go(input logic r, input logic [7:0] d);
    tick();
    uart_go = 1'b1;
    rors    = r;
    tx_data = d;
    go_cyc  = cyc;
    tick();
    uart_go = 1'b0;
  endtask

  // Start bit is driven right after edge frame_start_cyc; each bit lasts
  // CPB cycles; one idle bit time follows the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    tick();
    frame_start_cyc = cyc;
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      rxd = 1'b0;
      else if (j == 9) rxd = stop_bit;
      else             rxd = b[j-1];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int start;
    start = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; rxd = 1'b1; uart_go = 1'b0; rors = 1'b0; tx_data = 8'h00;
    repeat (5) tick();
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_cmp++; if (uart_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", uart_done); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    n_cmp++; if (cmd_state !== 2'd0) begin n_bad++; $display("FAIL reset_cmd_state: got %0d expected 0", cmd_state); end
    n_cmp++; if (rx_state !== 3'd0) begin n_bad++; $display("FAIL reset_rx_state: got %0d expected 0", rx_state); end
    rstn = 1'b1;
    repeat (5) tick();
  endtask

  // A5 on the line, LSB first with start/stop: 0,1,0,1,0,0,1,0,1,1
  task automatic test_send();
    logic [9:0] exp_bits;
    int n0;
    exp_bits = 10'b11_0100_1010;
    n0 = done_cnt;
    issue_go(1'b1, 8'hA5);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (txd !== exp_bits[(c-1)/CPB]) begin
        n_bad++;
        $display("FAIL send_txd cycle +%0d: got %b expected %b", c, txd, exp_bits[(c-1)/CPB]);
      end
      // A receive strobe while busy must be ignored.
      if (c == 5) begin uart_go = 1'b1; rors = 1'b0; end
      if (c == 6) uart_go = 1'b0;
    end
    repeat (4) tick();
    n_cmp++; if (done_cnt - n0 !== 1) begin n_bad++; $display("FAIL send_done_count: got %0d expected 1", done_cnt - n0); end
    n_cmp++; if (last_done_cyc !== go_cyc + 41) begin n_bad++; $display("FAIL send_done_cycle: got %0d expected %0d", last_done_cyc, go_cyc + 41); end
    n_cmp++; if (cmd_state !== 2'd0) begin n_bad++; $display("FAIL send_ignored_go: cmd_state got %0d expected 0", cmd_state); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL send_idle_txd: got %b expected 1", txd); end
  endtask

  task automatic test_receive_after();
    bit seen;
    send_frame(8'h3C, 1'b1);
    issue_go(1'b0, 8'h00);
    wait_done(10, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rx_after_done: got none expected pulse"); end
    n_cmp++; if (last_done_cyc !== go_cyc + 2) begin n_bad++; $display("FAIL rx_after_latency: got %0d expected %0d", last_done_cyc, go_cyc + 2); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL rx_after_data: got %h expected 3c", rx_data); end
  endtask

  // Stop-bit center (push) lands on edge frame_start_cyc+41, pop on +42.
  task automatic test_receive_before();
    int n0;
    issue_go(1'b0, 8'h00);
    n0 = done_cnt;
    repeat (5) tick();
    n_cmp++; if (cmd_state !== 2'd2) begin n_bad++; $display("FAIL rx_before_wait: cmd_state got %0d expected 2", cmd_state); end
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL rx_before_early: got %0d pulses expected 0", done_cnt - n0); end
    send_frame(8'h81, 1'b1);
    n_cmp++; if (done_cnt - n0 !== 1) begin n_bad++; $display("FAIL rx_before_count: got %0d expected 1", done_cnt - n0); end
    n_cmp++; if (last_done_cyc !== frame_start_cyc + 42) begin n_bad++; $display("FAIL rx_before_latency: got %0d expected %0d", last_done_cyc, frame_start_cyc + 42); end
    n_cmp++; if (rx_data !== 8'h81) begin n_bad++; $display("FAIL rx_before_data: got %h expected 81", rx_data); end
  endtask

  task automatic test_overrun();
    bit seen;
    logic [7:0] exp;
    int n0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      if (v <= 4) exp_q.push_back(8'(v));
    end
    n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_flag: got %b expected 1", rx_overrun); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL overrun_frame_err: got %b expected 0", rx_frame_err); end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      issue_go(1'b0, 8'h00);
      wait_done(10, seen);
      n_cmp++;
      if (!seen || rx_data !== exp) begin
        n_bad++;
        $display("FAIL overrun_pop: got %h (done %0d) expected %h", rx_data, seen, exp);
      end
    end
    // Queue must now be empty: the dropped 05 must not come out.
    n0 = done_cnt;
    issue_go(1'b0, 8'h00);
    repeat (20) tick();
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL overrun_empty: got %0d pulses expected 0 (rx_data %h)", done_cnt - n0, rx_data); end
    send_frame(8'h77, 1'b1);
    n_cmp++; if (done_cnt - n0 !== 1 || rx_data !== 8'h77) begin n_bad++; $display("FAIL overrun_next: got %h expected 77", rx_data); end
  endtask

  task automatic test_errors();
    int n0;
    tick(); rxd = 1'b0;
    tick(); rxd = 1'b1;
    repeat (10) tick();
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL glitch_flag: got %b expected 0", rx_frame_err); end
    n_cmp++; if (rx_state !== 3'd0) begin n_bad++; $display("FAIL glitch_rx_state: got %0d expected 0", rx_state); end
    send_frame(8'h5A, 1'b0);
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_flag: got %b expected 1", rx_frame_err); end
    n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b expected 1", rx_overrun); end
    // Neither the glitch nor the bad frame may have queued anything.
    n0 = done_cnt;
    issue_go(1'b0, 8'h00);
    repeat (20) tick();
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL errors_no_push: got %0d pulses expected 0 (rx_data %h)", done_cnt - n0, rx_data); end
    send_frame(8'hC3, 1'b1);
    n_cmp++; if (done_cnt - n0 !== 1 || rx_data !== 8'hC3) begin n_bad++; $display("FAIL errors_next: got %h expected c3", rx_data); end
    n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_sticky: got %b expected 1", rx_frame_err); end
  endtask

  task automatic test_reset_mid();
    int n0;
    int low_seen;
    n0 = done_cnt;
    issue_go(1'b1, 8'h00);
    repeat (15) tick();
    rstn = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mid_send_txd: got %b expected 1", txd); end
    n_cmp++; if (cmd_state !== 2'd0) begin n_bad++; $display("FAIL mid_send_state: got %0d expected 0", cmd_state); end
    n_cmp++; if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL mid_send_flags: got %b%b expected 00", rx_overrun, rx_frame_err); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_send_rx_data: got %h expected 00", rx_data); end
    repeat (3) tick();
    rstn = 1'b1;
    low_seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    n_cmp++; if (low_seen !== 0) begin n_bad++; $display("FAIL mid_send_line: got %0d low cycles expected 0", low_seen); end
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL mid_send_done: got %0d pulses expected 0", done_cnt - n0); end

    fork
      send_frame(8'h00, 1'b1);
      begin
        repeat (16) tick();
        rstn = 1'b0;
        #1;
        n_cmp++; if (rx_state !== 3'd0) begin n_bad++; $display("FAIL mid_rx_state: got %0d expected 0", rx_state); end
        repeat (30) tick();
        rstn = 1'b1;
      end
    join
    repeat (4) tick();
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL mid_rx_done: got %0d pulses expected 0", done_cnt - n0); end
    n_cmp++; if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL mid_rx_flags: got %b%b expected 00", rx_overrun, rx_frame_err); end
    issue_go(1'b0, 8'h00);
    repeat (20) tick();
    n_cmp++; if (done_cnt !== n0) begin n_bad++; $display("FAIL mid_rx_queue_empty: got %0d pulses expected 0 (rx_data %h)", done_cnt - n0, rx_data); end
    send_frame(8'hE7, 1'b1);
    n_cmp++; if (done_cnt - n0 !== 1 || rx_data !== 8'hE7) begin n_bad++; $display("FAIL mid_rx_rearm: got %h expected e7", rx_data); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_send();
    test_receive_after();
    test_receive_before();
    test_overrun();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
